// File: rtl/risc_ctrl_pkg.sv
// Shared types and encodings for the RISC controller FSM and its memory timer.
// The optional HALT instruction is enabled with the RISC_CTRL_HALT_EN macro.
package risc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_WAIT,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_C,
        S_ADDR,
        S_LATCH,
        S_MEM_RD,
        S_WR_MEM,
        S_ST_B,
        S_ST_C,
        S_MEM_WR,
        S_HALT
    } state_t;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MEM     = 2'b00;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [3:0] VSEL_NONE   = 4'b0000;
    localparam logic [3:0] VSEL_MDATA  = 4'b0001;
    localparam logic [3:0] VSEL_SXIMM8 = 4'b0010;
    localparam logic [3:0] VSEL_PC     = 4'b0100;
    localparam logic [3:0] VSEL_C      = 4'b1000;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // Datapath strobes that depend only on the state and the latched instruction.
    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [3:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       load_addr;
        logic [1:0] mem_cmd;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t st);
        return (st == S_MEM_RD) || (st == S_MEM_WR);
    endfunction

    // Control word for a state; the instruction only matters in EXEC.
    function automatic ctrl_t ctrl_of(input state_t st, input logic [4:0] ir);
        ctrl_t c;
        c         = '0;
        c.nsel    = NSEL_NONE;
        c.vsel    = VSEL_NONE;
        c.mem_cmd = MEM_NONE;
        case (st)
            S_WAIT:   c.w = 1'b1;
            S_WR_IMM: begin c.nsel = NSEL_RN; c.vsel = VSEL_SXIMM8; c.write = 1'b1; end
            S_GET_A:  begin c.nsel = NSEL_RN; c.loada = 1'b1; end
            S_GET_B:  begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
            S_EXEC: begin
                if (ir == {OPC_ALU, OP_CMP}) begin
                    c.loads = 1'b1;
                end else begin
                    c.loadc = 1'b1;
                    // MOV reg and MVN pass B through the ALU with A forced to zero.
                    c.asel  = (ir == {OPC_MOV, OP_MOV_REG}) || (ir == {OPC_ALU, OP_MVN});
                end
            end
            S_WR_C:   begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
            S_ADDR:   begin c.bsel = 1'b1; c.loadc = 1'b1; end
            S_LATCH:  c.load_addr = 1'b1;
            S_MEM_RD: c.mem_cmd = MEM_READ;
            S_WR_MEM: begin c.nsel = NSEL_RD; c.vsel = VSEL_MDATA; c.write = 1'b1; end
            S_ST_B:   begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
            S_ST_C:   begin c.asel = 1'b1; c.loadc = 1'b1; end
            S_MEM_WR: c.mem_cmd = MEM_WRITE;
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/risc_ctrl_mem_timer.sv
// Memory-wait timeout counter: cleared on entry to a memory state, counts
// cycles without mem_rdy, flags the last allowed wait cycle. MEM_TIMEOUT=0
// disables the timeout.
module risc_ctrl_mem_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic active_i,
    input  logic rdy_i,
    output logic expired_o
);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count wait cycles; restart whenever a new memory access begins.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset || start_i) begin
            cnt_q <= '0;
        end else if (active_i && !rdy_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (MEM_TIMEOUT != 0) && active_i && (cnt_q == LAST);

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Simple RISC Machine controller FSM with LDR/STR and a memory-wait timeout.
// Define RISC_CTRL_HALT_EN to add the HALT instruction (111_00) and the halted port.
module risc_ctrl_fsm
    import risc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CMD_W       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    input  logic             mem_rdy,
    output logic             w,
    output logic [2:0]       nsel,
    output logic [3:0]       vsel,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic             load_addr,
    output logic [CMD_W-1:0] mem_cmd,
    output logic             illegal,
`ifdef RISC_CTRL_HALT_EN
    output logic             halted,
`endif
    output logic             mem_err
);

    state_t     state_q, state_d;
    logic [4:0] ir_q, ir_d;
    ctrl_t      ctrl_q;
    logic       illegal_q;
    logic       expired;

    // First state after DECODE; S_WAIT marks an undefined instruction.
    function automatic state_t decode_target(input logic [4:0] ir);
        state_t nxt;
        case (ir)
            {OPC_MOV, OP_MOV_IMM}: nxt = S_WR_IMM;
            {OPC_MOV, OP_MOV_REG}: nxt = S_GET_B;
            {OPC_ALU, OP_ADD},
            {OPC_ALU, OP_CMP},
            {OPC_ALU, OP_AND}:     nxt = S_GET_A;
            {OPC_ALU, OP_MVN}:     nxt = S_GET_B;
            {OPC_LDR, OP_MEM},
            {OPC_STR, OP_MEM}:     nxt = S_GET_A;
`ifdef RISC_CTRL_HALT_EN
            {OPC_HALT, OP_MEM}:    nxt = S_HALT;
`endif
            default:               nxt = S_WAIT;
        endcase
        return nxt;
    endfunction

    // Next state; the instruction is captured at start so later IR changes cannot redirect it.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    ir_d    = {opcode, op};
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = decode_target(ir_q);
            S_WR_IMM: state_d = S_WAIT;
            S_GET_A:  state_d = (ir_q[4:2] == OPC_LDR || ir_q[4:2] == OPC_STR) ? S_ADDR : S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = (ir_q == {OPC_ALU, OP_CMP}) ? S_WAIT : S_WR_C;
            S_WR_C:   state_d = S_WAIT;
            S_ADDR:   state_d = S_LATCH;
            S_LATCH:  state_d = (ir_q[4:2] == OPC_LDR) ? S_MEM_RD : S_ST_B;
            S_MEM_RD: begin
                if (mem_rdy)      state_d = S_WR_MEM;
                else if (expired) state_d = S_WAIT;
            end
            S_WR_MEM: state_d = S_WAIT;
            S_ST_B:   state_d = S_ST_C;
            S_ST_C:   state_d = S_MEM_WR;
            S_MEM_WR: begin
                if (mem_rdy || expired) state_d = S_WAIT;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_WAIT;
        endcase
    end

    // State register with outputs registered from the next state, so they are a pure function of state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAIT;
            ir_q      <= '0;
            ctrl_q    <= ctrl_of(S_WAIT, '0);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ctrl_q    <= ctrl_of(state_d, ir_d);
            illegal_q <= (state_d == S_DECODE) && (decode_target(ir_d) == S_WAIT);
        end
    end

    risc_ctrl_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .start_i  (is_mem_state(state_d) && !is_mem_state(state_q)),
        .active_i (is_mem_state(state_q)),
        .rdy_i    (mem_rdy),
        .expired_o(expired)
    );

    assign w         = ctrl_q.w;
    assign nsel      = ctrl_q.nsel;
    assign vsel      = ctrl_q.vsel;
    assign write     = ctrl_q.write;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign load_addr = ctrl_q.load_addr;
    assign mem_cmd   = CMD_W'(ctrl_q.mem_cmd);
    assign illegal   = illegal_q;
    // A late mem_rdy on the expiry cycle still completes the access, hence the gate.
    assign mem_err   = expired && !mem_rdy;
`ifdef RISC_CTRL_HALT_EN
    assign halted    = (state_q == S_HALT);
`endif

endmodule
